// File: rtl/tx_frame_ctrl_if.sv
// Byte-stream handshake between a PSDU byte source (master) and the
// 802.11a frame controller (slave). The slave pulses byte_ready on the
// cycle it takes byte_in; byte_valid says whether the source had one.
interface tx_frame_ctrl_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/tx_frame_ctrl.sv
// 802.11a transmit frame controller: computes pad bits for the frame,
// then serialises zero preamble bits, SIGNAL, SERVICE, PSDU and tail
// bits on tx_bit, one bit per clock.
// Optional build macro: TXC_LEN_CHECK_EN rejects starts whose length is
// 0 or larger than MAX_LEN. Without it every length is taken and a zero
// length frame goes straight from SERVICE to TAIL.
module tx_frame_ctrl #(
    parameter int PREAMBLE_BITS = 12,
    parameter int MAX_LEN       = 2346
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  rate,
    input  logic [11:0] length,
    tx_frame_ctrl_if.slave src,
    output logic        tx_bit,
    output logic        tx_reset,
    output logic [7:0]  n_pad,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        err
);

    // Parameter sanity: the bit counter is 16 bits and length is 12 bits.
    if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 65535) begin : g_bad_preamble
        $error("tx_frame_ctrl: PREAMBLE_BITS out of range");
    end
    if (MAX_LEN < 1 || MAX_LEN > 4095) begin : g_bad_max_len
        $error("tx_frame_ctrl: MAX_LEN out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_PREAMBLE, S_SIGNAL, S_SERVICE, S_PSDU, S_TAIL, S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [3:0]  rate_reg, rate_next;
    logic [11:0] len_reg, len_next;
    logic [7:0]  ndbps_reg, ndbps_next;
    logic [15:0] rem_reg, rem_next;
    logic [7:0]  n_pad_reg, n_pad_next;
    logic [7:0]  sh_reg, sh_next;
    logic        tx_bit_reg, tx_bit_next;
    logic        err_reg, err_next;

    logic        rate_ok;
    logic [7:0]  rate_ndbps;
    logic        len_ok;
    logic        load;
    logic [7:0]  load_byte;
    logic [23:0] sig_word;

`ifdef TXC_LEN_CHECK_EN
    assign len_ok = (length != 12'd0) && (32'(length) <= MAX_LEN);
`else
    assign len_ok = 1'b1;
`endif

    // SIGNAL field, transmitted from bit 23 down: RATE, reserved, LENGTH,
    // even parity over the first 17 bits, six zero tail bits.
    assign sig_word = {rate_reg, 1'b0, len_reg, ^{rate_reg, len_reg}, 6'b000000};

    // A missing byte is replaced by zeros so the frame timing never moves.
    assign load_byte = src.byte_valid ? src.byte_in : 8'h00;

    // RATE code to data bits per OFDM symbol; unknown codes are rejected.
    always_comb begin
        rate_ok    = 1'b1;
        rate_ndbps = 8'd0;
        case (rate)
            4'b1101: rate_ndbps = 8'd24;
            4'b1111: rate_ndbps = 8'd36;
            4'b0101: rate_ndbps = 8'd48;
            4'b0111: rate_ndbps = 8'd72;
            4'b1001: rate_ndbps = 8'd96;
            4'b1011: rate_ndbps = 8'd144;
            4'b0001: rate_ndbps = 8'd192;
            4'b0011: rate_ndbps = 8'd216;
            default: rate_ok    = 1'b0;
        endcase
    end

    // Next-state and datapath: cnt_reg counts cycles within the current state.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg + 16'd1;
        rate_next   = rate_reg;
        len_next    = len_reg;
        ndbps_next  = ndbps_reg;
        rem_next    = rem_reg;
        n_pad_next  = n_pad_reg;
        sh_next     = sh_reg;
        tx_bit_next = 1'b0;
        err_next    = 1'b0;
        load        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = 16'd0;
                if (start) begin
                    if (rate_ok && len_ok) begin
                        rate_next  = rate;
                        len_next   = length;
                        ndbps_next = rate_ndbps;
                        rem_next   = 16'd22 + {1'b0, length, 3'b000};
                        state_next = S_CALC;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CALC: begin
                // Strip whole symbols until the remainder fits in one; the
                // unused part of that last symbol is the pad.
                cnt_next = 16'd0;
                if (rem_reg > {8'h00, ndbps_reg}) begin
                    rem_next = rem_reg - {8'h00, ndbps_reg};
                end else begin
                    n_pad_next = ndbps_reg - rem_reg[7:0];
                    state_next = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (cnt_reg == 16'(PREAMBLE_BITS - 1)) begin
                    cnt_next   = 16'd0;
                    state_next = S_SIGNAL;
                end
            end
            S_SIGNAL: begin
                tx_bit_next = sig_word[5'd23 - cnt_reg[4:0]];
                if (cnt_reg == 16'd23) begin
                    cnt_next   = 16'd0;
                    state_next = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (cnt_reg == 16'd15) begin
                    cnt_next   = 16'd0;
                    state_next = (len_reg == 12'd0) ? S_TAIL : S_PSDU;
                end
            end
            S_PSDU: begin
                if (cnt_reg[2:0] == 3'd0) begin
                    load        = 1'b1;
                    sh_next     = load_byte;
                    tx_bit_next = load_byte[0];
                end else begin
                    tx_bit_next = sh_reg[cnt_reg[2:0]];
                end
                if (cnt_reg == {1'b0, len_reg, 3'b000} - 16'd1) begin
                    cnt_next   = 16'd0;
                    state_next = S_TAIL;
                end
            end
            S_TAIL: begin
                if (cnt_reg == {8'h00, n_pad_reg} + 16'd5) begin
                    cnt_next   = 16'd0;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                cnt_next   = 16'd0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 16'd0;
            rate_reg   <= 4'd0;
            len_reg    <= 12'd0;
            ndbps_reg  <= 8'd0;
            rem_reg    <= 16'd0;
            n_pad_reg  <= 8'd0;
            sh_reg     <= 8'd0;
            tx_bit_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rate_reg   <= rate_next;
            len_reg    <= len_next;
            ndbps_reg  <= ndbps_next;
            rem_reg    <= rem_next;
            n_pad_reg  <= n_pad_next;
            sh_reg     <= sh_next;
            tx_bit_reg <= tx_bit_next;
            err_reg    <= err_next;
        end
    end

    // Byte strobes are masked while reset is low so an abort never consumes a byte.
    assign src.byte_ready = load & reset;
    assign underrun       = load & reset & ~src.byte_valid;

    assign tx_bit   = tx_bit_reg;
    assign err      = err_reg;
    assign n_pad    = n_pad_reg;
    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign tx_reset = (state_reg == S_IDLE) || (state_reg == S_CALC) || (state_reg == S_DONE);

endmodule
